rf_wr_arbiter: RTL and testbench

//   Shares the single GPR write port among NREQ writeback requesters. The GPR file is built

---
 rtl/rf_wr_arbiter.sv | 83 ++++++++
 tb/tb_rf_wr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: round-robin arbiter sharing one GPR write port; optional stats via RF_ARB_STATS_EN
module rf_wr_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              rf_hold,
  output logic              rf_wen,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic              arb_busy
`ifdef RF_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [NREQ*16-1:0] stat_cnt
`endif
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] rr_ptr, win;
  logic          win_any, can_accept, xfer, out_valid;
  logic [AW-1:0] out_addr, sel_addr;
  logic [DW-1:0] out_data, sel_data;
  int            idx;
  // pick the first valid requester starting from the round-robin pointer
  always_comb begin
    win = '0;
    win_any = 1'b0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!win_any && req_valid[idx]) begin
        win = PW'(idx);
        win_any = 1'b1;
      end
    end
  end
  // the stage can take a new write when empty or when its current write commits now
  always_comb begin
    can_accept = !out_valid || !rf_hold;
    xfer = win_any && can_accept;
    req_ready = xfer ? (NREQ'(1) << win) : '0;
    sel_addr = req_addr[int'(win)*AW +: AW];
    sel_data = req_data[int'(win)*DW +: DW];
    rf_wen = out_valid;
    arb_busy = out_valid;
    rf_waddr = out_addr;
    rf_wdata = out_data;
  end
  // output stage and pointer; x0 transfers consume the turn but never raise the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= PW'((int'(win) + 1) % NREQ);
      out_valid <= sel_addr != '0;
      if (sel_addr != '0) begin
        out_addr <= sel_addr;
        out_data <= sel_data;
      end
    end else if (!rf_hold) begin
      out_valid <= 1'b0;
    end
  end
`ifdef RF_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt;
  assign stat_cnt = cnt;
  // saturating per-requester count of real (non-x0) writes; clear beats increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (stat_clr) cnt <= '0;
    else if (xfer && sel_addr != '0 && cnt[win] != 16'hFFFF) cnt[win] <= cnt[win] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed self-checking bench for rf_wr_arbiter
module tb_rf_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        rf_hold, rf_wen, arb_busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  int checks = 0;
  int errors = 0;
`ifdef RF_ARB_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_cnt;
`endif

  rf_wr_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .rf_hold(rf_hold),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .arb_busy(arb_busy)
`ifdef RF_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    rf_hold = 1'b0;
`ifdef RF_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    #2;
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 2'b01;
    req_addr = {5'd0, 5'd5};
    req_data = {32'd0, 32'hDEADBEEF};
    #1 chk("single_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("single_wen", rf_wen, 1);
    chk("single_waddr", rf_waddr, 5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    chk("single_busy", arb_busy, 1);
    step();
    chk("single_wen_off", rf_wen, 0);
    req_valid = 2'b11;
    req_addr = {5'd2, 5'd1};
    req_data = {32'hBBBB, 32'hAAAA};
    for (int k = 0; k < 4; k++) begin
      #1 chk("cont_ready", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
      if (k == 3) req_valid = '0;
      chk("cont_wen", rf_wen, 1);
      chk("cont_waddr", rf_waddr, (k % 2 == 0) ? 2 : 1);
      chk("cont_wdata", rf_wdata, (k % 2 == 0) ? 32'hBBBB : 32'hAAAA);
    end
    step();
    chk("cont_wen_off", rf_wen, 0);
    req_valid = 2'b01;
    req_addr = {5'd4, 5'd3};
    req_data = {32'h44, 32'h33};
    #1 chk("hold_ready0", req_ready, 2'b01);
    step();
    rf_hold = 1'b1;
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1 chk("hold_ready", req_ready, 0);
      chk("hold_wen", rf_wen, 1);
      chk("hold_waddr", rf_waddr, 3);
      chk("hold_wdata", rf_wdata, 32'h33);
      step();
    end
    rf_hold = 1'b0;
    #1 chk("hold_release_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    chk("b2b_wen", rf_wen, 1);
    chk("b2b_waddr", rf_waddr, 4);
    chk("b2b_wdata", rf_wdata, 32'h44);
    step();
    chk("b2b_wen_off", rf_wen, 0);
    req_valid = 2'b01;
    req_addr = {5'd0, 5'd0};
    req_data = {32'd7, 32'd7};
    #1 chk("x0a_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("x0a_wen", rf_wen, 0);
    req_valid = 2'b11;
    req_addr = {5'd0, 5'd8};
    req_data = {32'd7, 32'h88};
    #1 chk("x0_ptr_adv", req_ready, 2'b10);
    step();
    chk("x0b_wen", rf_wen, 0);
    req_addr = {5'd9, 5'd8};
    req_data = {32'h99, 32'h88};
    #1 chk("x0b_ptr", req_ready, 2'b01);
    step();
    req_valid = '0;
    rf_hold = 1'b1;
    chk("pre_rst_wen", rf_wen, 1);
    chk("pre_rst_waddr", rf_waddr, 8);
    rst = 1'b1;
    #1;
    chk("async_rst_wen", rf_wen, 0);
    chk("async_rst_busy", arb_busy, 0);
    chk("async_rst_waddr", rf_waddr, 0);
    step();
    rst = 1'b0;
    rf_hold = 1'b0;
    req_valid = 2'b11;
    #1 chk("post_rst_ready", req_ready, 2'b01);
    step();
    req_valid = '0;
    chk("post_rst_waddr", rf_waddr, 8);
    chk("post_rst_wdata", rf_wdata, 32'h88);
    step();
    chk("empty_wen", rf_wen, 0);
    rf_hold = 1'b1;
    req_valid = 2'b10;
    req_addr = {5'd10, 5'd0};
    req_data = {32'h55, 32'd0};
    #1 chk("hold_empty_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    chk("hold_empty_wen", rf_wen, 1);
    chk("hold_empty_waddr", rf_waddr, 10);
    step();
    chk("hold_empty_keep", rf_wen, 1);
    rf_hold = 1'b0;
    step();
    chk("hold_empty_done", rf_wen, 0);
`ifdef RF_ARB_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stat_clr0", stat_cnt, 0);
    req_valid = 2'b01;
    req_addr = {5'd0, 5'd5};
    step();
    step();
    step();
    req_valid = 2'b10;
    step();
    req_valid = '0;
    chk("stat_cnt", stat_cnt, {16'd0, 16'd3});
    req_valid = 2'b01;
    stat_clr = 1'b1;
    step();
    req_valid = '0;
    stat_clr = 1'b0;
    chk("stat_clr_wins", stat_cnt, 0);
    force dut.cnt = {16'd0, 16'hFFFF};
    #1 release dut.cnt;
    req_valid = 2'b01;
    step();
    req_valid = '0;
    chk("stat_sat", stat_cnt, {16'd0, 16'hFFFF});
`endif
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
